// File: rtl/aidc_lite_comp_mc_sched.sv
// ----------------------------------------------------------------------------
// aidc_lite_comp_mc_sched
//   Multi-channel job scheduler for the AIDC-Lite compression engine.
//   Holds CH_CNT job descriptors (src, dst, len) programmed over APB, picks
//   pending jobs round-robin and hands them to the shared engine one at a
//   time over a start/done pulse handshake.
//
//   Optional feature macro: AIDC_LITE_COMP_MC_IRQ_EN (per-channel completion
//   interrupt with IRQ_STAT/IRQ_MASK registers at 0x204/0x208).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   psel .. pwdata        APB slave request (12-bit byte address)
//   prdata, pready,
//   pslverr               APB response, zero wait states
//   src_addr_o,
//   dst_addr_o, len_o,
//   ch_id_o               descriptor of the granted job, held until next grant
//   start_o               one-cycle job start pulse
//   done_i                one-cycle engine completion pulse
//   irq_o                 completion interrupt (0 unless the macro is defined)
// ----------------------------------------------------------------------------
module aidc_lite_comp_mc_sched #(
    parameter int unsigned CH_CNT = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic [11:0]       paddr,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [24:0]       len_o,
    output logic [3:0]        ch_id_o,
    output logic              start_o,
    input  logic              done_i,
    output logic              irq_o
);

    localparam logic [4:0]  OFF_SRC    = 5'h00;
    localparam logic [4:0]  OFF_DST    = 5'h04;
    localparam logic [4:0]  OFF_LEN    = 5'h08;
    localparam logic [4:0]  OFF_CMD    = 5'h0C;
    localparam logic [4:0]  OFF_STAT   = 5'h10;
    localparam logic [11:0] ADDR_ACT   = 12'h200;
    localparam logic [11:0] ADDR_ISTAT = 12'h204;
    localparam logic [11:0] ADDR_IMASK = 12'h208;
    localparam logic [4:0]  CH_CNT5    = 5'(CH_CNT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e r_state, w_state_d;

    logic [ADDR_W-1:0] r_src [CH_CNT];
    logic [ADDR_W-1:0] r_dst [CH_CNT];
    logic [24:0]       r_len [CH_CNT];
    logic [CH_CNT-1:0] r_pend, r_busy, r_done;
    logic [3:0]        r_rr;
    logic [ADDR_W-1:0] r_src_out, r_dst_out;
    logic [24:0]       r_len_out;
    logic [3:0]        r_ch_id;

    // ---------------- APB decode ----------------
    logic              w_access, w_wr, w_rd, w_we;
    logic              w_ch_ok, w_off_ok, w_glob_hit, w_mapped, w_locked;
    logic              w_is_desc, w_is_cmd, w_is_stat, w_kick_req, w_err;
    logic [3:0]        w_ch;
    logic [4:0]        w_off;
    logic [CH_CNT-1:0] w_sel, w_kick_vec, w_w1c_vec;

    assign w_access   = psel & penable;
    assign w_wr       = w_access & pwrite;
    assign w_rd       = w_access & ~pwrite;
    assign w_ch       = paddr[8:5];
    assign w_off      = paddr[4:0];
    assign w_ch_ok    = (paddr[11:9] == 3'b000) && ({1'b0, w_ch} < CH_CNT5);
    assign w_is_desc  = (w_off == OFF_SRC) || (w_off == OFF_DST) || (w_off == OFF_LEN);
    assign w_is_cmd   = (w_off == OFF_CMD);
    assign w_is_stat  = (w_off == OFF_STAT);
    assign w_off_ok   = w_is_desc || w_is_cmd || w_is_stat;
    assign w_kick_req = w_is_cmd & pwdata[0];
`ifdef AIDC_LITE_COMP_MC_IRQ_EN
    assign w_glob_hit = (paddr == ADDR_ACT) || (paddr == ADDR_ISTAT) || (paddr == ADDR_IMASK);
`else
    assign w_glob_hit = (paddr == ADDR_ACT);
`endif
    assign w_mapped   = (w_ch_ok & w_off_ok) | w_glob_hit;

    always_comb begin
        w_sel = '0;
        for (int c = 0; c < CH_CNT; c++) begin
            w_sel[c] = w_ch_ok && (w_ch == 4'(c));
        end
    end

    // A job the engine owns (or is about to own) must not change under it.
    assign w_locked = |(w_sel & (r_pend | r_busy));
    assign w_err    = w_access & (~w_mapped |
                      (pwrite & w_ch_ok & w_locked & (w_is_desc | w_kick_req)));
    assign w_we     = w_wr & ~w_err;

    assign w_kick_vec = (w_we && w_ch_ok && w_kick_req)           ? w_sel : '0;
    assign w_w1c_vec  = (w_we && w_ch_ok && w_is_stat && pwdata[2]) ? w_sel : '0;

    // ---------------- Round-robin pick ----------------
    logic [2*CH_CNT-1:0] w_pend2;
    logic [4:0]          w_sum;
    logic [3:0]          w_pick;
    logic                w_any_pend;
    logic [ADDR_W-1:0]   w_pick_src, w_pick_dst;
    logic [24:0]         w_pick_len;

    always_comb begin
        // Rotate so bit 0 is the channel at the rr pointer; first set bit wins.
        w_pend2    = {r_pend, r_pend} >> r_rr;
        w_any_pend = 1'b0;
        w_pick     = '0;
        w_sum      = '0;
        for (int i = 0; i < CH_CNT; i++) begin
            if (!w_any_pend && w_pend2[i]) begin
                w_any_pend = 1'b1;
                w_sum      = {1'b0, r_rr} + 5'(i);
                if (w_sum >= CH_CNT5) begin
                    w_sum = w_sum - CH_CNT5;
                end
                w_pick = w_sum[3:0];
            end
        end
        w_pick_src = '0;
        w_pick_dst = '0;
        w_pick_len = '0;
        for (int c = 0; c < CH_CNT; c++) begin
            if (w_pick == 4'(c)) begin
                w_pick_src = r_src[c];
                w_pick_dst = r_dst[c];
                w_pick_len = r_len[c];
            end
        end
    end

    // ---------------- Job FSM ----------------
    logic              w_issue, w_fin;
    logic [CH_CNT-1:0] w_cur_vec, w_done_set;

    always_comb begin
        w_cur_vec = '0;
        for (int c = 0; c < CH_CNT; c++) begin
            w_cur_vec[c] = (r_ch_id == 4'(c));
        end
    end

    assign w_issue    = (r_state == StIssue);
    assign w_fin      = (r_state == StWait) & done_i;
    assign w_done_set = w_fin ? w_cur_vec : '0;

    always_comb begin
        w_state_d = r_state;
        start_o   = 1'b0;
        case (r_state)
            StIdle:  if (w_any_pend) w_state_d = StIssue;
            StIssue: begin
                start_o   = 1'b1;
                w_state_d = StWait;
            end
            StWait:  if (done_i) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_out <= '0;
            r_dst_out <= '0;
            r_len_out <= '0;
            r_ch_id   <= '0;
            r_rr      <= '0;
        end else begin
            if (r_state == StIdle && w_any_pend) begin
                r_src_out <= w_pick_src;
                r_dst_out <= w_pick_dst;
                r_len_out <= w_pick_len;
                r_ch_id   <= w_pick;
            end
            if (w_fin) begin
                r_rr <= (r_ch_id == 4'(CH_CNT - 1)) ? 4'd0 : r_ch_id + 4'd1;
            end
        end
    end

    // ---------------- Channel state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_CNT; c++) begin
                r_src[c] <= '0;
                r_dst[c] <= '0;
                r_len[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH_CNT; c++) begin
                if (w_we && w_sel[c]) begin
                    if (w_off == OFF_SRC) r_src[c] <= pwdata[ADDR_W-1:0];
                    if (w_off == OFF_DST) r_dst[c] <= pwdata[ADDR_W-1:0];
                    if (w_off == OFF_LEN) r_len[c] <= pwdata[31:7];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_busy <= '0;
            r_done <= '0;
        end else begin
            r_pend <= (r_pend | w_kick_vec) & ~(w_issue ? w_cur_vec : '0);
            r_busy <= (r_busy | (w_issue ? w_cur_vec : '0)) & ~w_done_set;
            // Hardware set beats a same-cycle W1C.
            r_done <= (r_done & ~w_w1c_vec) | w_done_set;
        end
    end

    // ---------------- Interrupt ----------------
`ifdef AIDC_LITE_COMP_MC_IRQ_EN
    logic [CH_CNT-1:0] r_irq_stat, r_irq_mask, w_irq_stat_d, w_irq_mask_d;
    logic              r_irq;

    always_comb begin
        w_irq_stat_d = r_irq_stat;
        w_irq_mask_d = r_irq_mask;
        if (w_we && paddr == ADDR_ISTAT) w_irq_stat_d = r_irq_stat & ~pwdata[CH_CNT-1:0];
        if (w_we && paddr == ADDR_IMASK) w_irq_mask_d = pwdata[CH_CNT-1:0];
        w_irq_stat_d = w_irq_stat_d | w_done_set;
    end

    // Built from next-state so irq_o rises the cycle right after done_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_stat <= '0;
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_stat <= w_irq_stat_d;
            r_irq_mask <= w_irq_mask_d;
            r_irq      <= |(w_irq_stat_d & w_irq_mask_d);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    // ---------------- Read data ----------------
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        if (w_rd && w_mapped) begin
            if (w_ch_ok) begin
                for (int c = 0; c < CH_CNT; c++) begin
                    if (w_sel[c]) begin
                        case (w_off)
                            OFF_SRC:  w_rdata = 32'(r_src[c]);
                            OFF_DST:  w_rdata = 32'(r_dst[c]);
                            OFF_LEN:  w_rdata = {r_len[c], 7'd0};
                            OFF_STAT: w_rdata = {29'd0, r_done[c], r_busy[c], r_pend[c]};
                            default:  w_rdata = '0;
                        endcase
                    end
                end
            end else if (paddr == ADDR_ACT) begin
                w_rdata = {(r_state != StIdle), 27'd0, r_ch_id};
            end
`ifdef AIDC_LITE_COMP_MC_IRQ_EN
            else if (paddr == ADDR_ISTAT) begin
                w_rdata = 32'(r_irq_stat);
            end else if (paddr == ADDR_IMASK) begin
                w_rdata = 32'(r_irq_mask);
            end
`endif
        end
    end

    assign prdata     = w_rdata;
    assign pslverr    = w_err;
    assign pready     = 1'b1;
    assign src_addr_o = r_src_out;
    assign dst_addr_o = r_dst_out;
    assign len_o      = r_len_out;
    assign ch_id_o    = r_ch_id;

endmodule
